axis_reg_loader: RTL and testbench
==================================

// Module: axis_reg_loader
// PURPOSE
//  Parametrised AXI-Stream register loader. Converts a framed stream of
//  [addr, d0..d(NREG-1)] records into a shadow-buffered register bank plus a
//  one-hot write-enable pulse per record. Sits between the tProcessor/DMA
//  stream and the signal-generator blocks (up to NB targets sharing one bus).
//  Adds over the previous generation: width/depth/target parameters, atomic
//  commit (no partial updates), address range check, error/status reporting.
// PARAMETERS
//  DW      32  data/register width (bits), >= $clog2(NB)
//  NREG    16  registers per record, 1..64
//  NB      64  number of write-enable targets
//  WE_LEN   8  write-enable pulse length in clk cycles, >= 1
// PORTS
//  clk            in   1          clock
//  rstn           in   1          synchronous reset, active-low
//  start          in   1          run request, level, asynchronous (2-flop sync inside)
//  s_axis_tvalid  in   1          stream valid
//  s_axis_tready  out  1          stream ready
//  s_axis_tdata   in   DW         stream data (addr beat or register beat)
//  s_axis_tlast   in   1          end of frame
//  we             out  NB         one-hot write enable, we[addr] for WE_LEN cycles
//  regs_out       out  NREG*DW    committed registers, reg i at [i*DW +: DW]
//  busy           out  1          state is ADDR, DATA or WRITE
//  done           out  1          state is DONE
//  err            out  1          sticky: short frame or address >= NB this run
//  blk_cnt        out  16         records committed with valid address this run (saturates)
// BEHAVIOUR
//  Reset: state IDLE; tready, we, regs_out, busy, done, err, blk_cnt, start sync all 0.
//  Beat = tvalid & tready. tready = (state==ADDR | state==DATA), combinational from state.
//  FSM:
//   IDLE : start_s=1 -> ADDR; clears err, blk_cnt on this transition.
//   ADDR : on beat, addr_r<=tdata[$clog2(NB)-1:0], addr_ok<=(tdata<NB).
//          tlast=1 on addr beat -> err<=1, DONE. else -> DATA, cnt<=0.
//   DATA : on beat shadow[cnt]<=tdata, cnt++.
//          cnt<NREG-1 & tlast -> err<=1, DONE; regs_out untouched (atomic).
//          cnt==NREG-1 -> regs_out<= shadow with tdata as last reg (same edge),
//          last_r<=tlast, -> WRITE. blk_cnt++ if addr_ok.
//   WRITE: WLEN cycles exactly; we[addr_r]=1 each cycle iff addr_ok, else we=0 and
//          err<=1 on entry. Exit: last_r ? DONE : ADDR.
//   DONE : hold; start_s=0 -> IDLE. err/blk_cnt/regs_out hold until next run.
//  Latency: final data beat at cycle T -> regs_out valid T+1, we high T+1..T+WE_LEN;
//   next addr beat accepted earliest T+WE_LEN+1. regs_out never changes while we!=0.
//  start_s only sampled in IDLE/DONE; deassert mid-frame has no effect.
//  tvalid low stalls ADDR/DATA indefinitely, no timeout. Addr beat upper bits ignored
//   for decode but included in range check (full DW compare).
//  blk_cnt saturates at 16'hFFFF. NREG=1: single data beat goes straight to WRITE.
//  Reset mid-frame: return to IDLE, regs_out cleared, we deasserted next edge.
// TESTING
//  1 NREG=16: start=1, frame addr=5, d=0x100..0x10F, tlast on d15 -> regs_out=0x100..0x10F
//    at T+1, we=1<<5 for 8 cycles, then done=1, blk_cnt=1, err=0.
//  2 Three back-to-back records (addr 0,1,63), tlast on last -> we pulses on bits 0,1,63
//    in order, no overlap, regs_out each time the record's data, blk_cnt=3.
//  3 Short frame: addr=2, 7 data beats, tlast on 7th -> err=1, done=1, we never high,
//    regs_out keeps previous values.
//  4 addr=64 (>=NB) full record -> regs_out updated, we stays 0, err=1, blk_cnt=0.
//  5 Random tvalid gaps (50%) on test 2 stream -> identical results; tready low in
//    WRITE/IDLE/DONE; start toggled low mid-frame ignored; done clears when start=0.
//  6 rstn=0 asserted during DATA beat 8 -> next cycle all outputs 0, state IDLE;
//    new run after reset completes normally.

Source files
------------

// File: rtl/axis_reg_loader_if.sv
// AXI-Stream bundle carrying address and register beats into axis_reg_loader.
// The master drives the beat, the slave returns tready.
interface axis_reg_loader_if #(
  parameter int DW = 32
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_reg_loader.sv
// Framed stream of [addr, d0..d(NREG-1)] records -> atomically committed register
// bank plus a WE_LEN-cycle one-hot write-enable pulse per record.
module axis_reg_loader #(
  parameter int DW     = 32,
  parameter int NREG   = 16,
  parameter int NB     = 64,
  parameter int WE_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  axis_reg_loader_if.slave     s_axis,
  output logic [NB-1:0]        we,
  output logic [NREG*DW-1:0]   regs_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          blk_cnt
);
  localparam int AW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int WW = (WE_LEN > 1) ? $clog2(WE_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(NREG - 1);
  localparam logic [WW-1:0] WCNT_LAST = WW'(WE_LEN - 1);
  localparam logic [DW-1:0] NB_LIM    = DW'(NB);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic            start_meta_r;
  logic            start_s_r;
  logic            tready_r;
  logic            beat_s;
  logic [AW-1:0]   addr_r;
  logic            addr_ok_r;
  logic [CW-1:0]   cnt_r;
  logic [WW-1:0]   wcnt_r;
  logic            last_r;
  logic [DW-1:0]   shadow_r [NREG];

  assign s_axis.tready = tready_r;
  assign beat_s        = s_axis.tvalid & tready_r;

  // Two-flop synchroniser for the asynchronous run request
  always_ff @(posedge clk) begin
    if (!rstn) begin
      start_meta_r <= 1'b0;
      start_s_r    <= 1'b0;
    end else begin
      start_meta_r <= start;
      start_s_r    <= start_meta_r;
    end
  end

  // State register; status outputs are registered from the next state so they track state_r exactly
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r  <= ST_IDLE;
      tready_r <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      tready_r <= (state_nx_s == ST_ADDR) || (state_nx_s == ST_DATA);
      busy     <= (state_nx_s == ST_ADDR) || (state_nx_s == ST_DATA) || (state_nx_s == ST_WRITE);
      done     <= (state_nx_s == ST_DONE);
    end
  end

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s_r) state_nx_s = ST_ADDR;
        else           state_nx_s = ST_IDLE;
      end
      ST_ADDR: begin
        if (beat_s) state_nx_s = s_axis.tlast ? ST_DONE : ST_DATA;
        else        state_nx_s = ST_ADDR;
      end
      ST_DATA: begin
        if (beat_s && (cnt_r == CNT_LAST))  state_nx_s = ST_WRITE;
        else if (beat_s && s_axis.tlast)    state_nx_s = ST_DONE;
        else                                state_nx_s = ST_DATA;
      end
      ST_WRITE: begin
        if (wcnt_r == WCNT_LAST) state_nx_s = last_r ? ST_DONE : ST_ADDR;
        else                     state_nx_s = ST_WRITE;
      end
      ST_DONE: begin
        if (!start_s_r) state_nx_s = ST_IDLE;
        else            state_nx_s = ST_DONE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Datapath: shadow capture, atomic commit, write-enable pulse and run status
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_r    <= '0;
      addr_ok_r <= 1'b0;
      cnt_r     <= '0;
      wcnt_r    <= '0;
      last_r    <= 1'b0;
      we        <= '0;
      regs_out  <= '0;
      err       <= 1'b0;
      blk_cnt   <= 16'd0;
      for (int i = 0; i < NREG; i++) shadow_r[i] <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s_r) begin
            err     <= 1'b0;
            blk_cnt <= 16'd0;
          end
        end
        ST_ADDR: begin
          if (beat_s) begin
            addr_r    <= s_axis.tdata[AW-1:0];
            addr_ok_r <= (s_axis.tdata < NB_LIM);
            cnt_r     <= '0;
            if (s_axis.tlast) err <= 1'b1;
          end
        end
        ST_DATA: begin
          if (beat_s) begin
            cnt_r <= cnt_r + CW'(1);
            if (cnt_r == CNT_LAST) begin
              // Final beat goes straight into the bank so the commit lands on one edge
              for (int i = 0; i < NREG - 1; i++) regs_out[i*DW +: DW] <= shadow_r[i];
              regs_out[(NREG-1)*DW +: DW] <= s_axis.tdata;
              last_r <= s_axis.tlast;
              wcnt_r <= '0;
              if (addr_ok_r) begin
                we <= NB'(1'b1) << addr_r;
                if (blk_cnt != 16'hFFFF) blk_cnt <= blk_cnt + 16'd1;
              end else begin
                err <= 1'b1;
              end
            end else begin
              shadow_r[cnt_r] <= s_axis.tdata;
              if (s_axis.tlast) err <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          wcnt_r <= wcnt_r + WW'(1);
          if (wcnt_r == WCNT_LAST) we <= '0;
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axis_reg_loader.sv
// Randomised directed bench for axis_reg_loader: a record-level model predicts pulses,
// committed registers and run status; a monitor collects every write-enable pulse.
module tb_axis_reg_loader;
  localparam int DW = 32, NREG = 16, NB = 64, WE_LEN = 8;
  localparam int RW = NREG * DW;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [NB-1:0] we;
  logic [RW-1:0] regs_out;
  logic busy, done, err;
  logic [15:0] blk_cnt;
  int total = 0, bad = 0;

  axis_reg_loader_if #(.DW(DW)) s_axis();

  axis_reg_loader #(.DW(DW), .NREG(NREG), .NB(NB), .WE_LEN(WE_LEN)) dut (
    .clk(clk), .rstn(rstn), .start(start), .s_axis(s_axis),
    .we(we), .regs_out(regs_out), .busy(busy), .done(done), .err(err), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [RW-1:0] m_regs = '0;
  bit            m_err;
  int            m_blk;
  int            exp_bit[$];
  logic [RW-1:0] exp_regs[$];
  int            got_bit[$], got_len[$];
  logic [RW-1:0] got_regs[$];
  logic [DW-1:0] beat_d[$];
  bit            beat_l[$];

  // pulse monitor
  int cur_len = 0, cur_bit = 0;
  logic [NB-1:0] cur_we;
  logic [RW-1:0] cur_regs;
  always @(negedge clk) begin
    if (!rstn) begin
      cur_len = 0;
    end else begin
      total++;
      assert (!(s_axis.tready === 1'b1 && (we !== '0 || done === 1'b1 || busy !== 1'b1)))
      else begin bad++; $error("FAIL tready_phase observed=%0b expected=0", s_axis.tready); end
      if (we !== '0) begin
        total++;
        assert ($onehot(we)) else begin bad++; $error("FAIL we_onehot observed=%0h expected=onehot", we); end
        if (cur_len == 0) begin
          cur_we = we; cur_regs = regs_out;
          for (int i = 0; i < NB; i++) if (we[i]) cur_bit = i;
        end else begin
          total++;
          assert (we === cur_we && regs_out === cur_regs)
          else begin bad++; $error("FAIL pulse_stable observed=%0h expected=%0h", we, cur_we); end
        end
        cur_len++;
      end else if (cur_len != 0) begin
        got_bit.push_back(cur_bit); got_len.push_back(cur_len); got_regs.push_back(cur_regs);
        cur_len = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
    total++;
    assert (obs === expv)
    else begin bad++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv); end
  endtask

  task automatic start_run();
    int n;
    m_err = 1'b0; m_blk = 0;
    exp_bit.delete(); exp_regs.delete(); got_bit.delete(); got_len.delete(); got_regs.delete();
    beat_d.delete(); beat_l.delete();
    start = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("start_busy", busy, 1);
  endtask

  task automatic add_record(input logic [DW-1:0] addr, input int nbeats, input bit last,
                            input bit rnd, input logic [DW-1:0] base);
    logic [RW-1:0] rec;
    logic [DW-1:0] d;
    rec = '0;
    beat_d.push_back(addr); beat_l.push_back(last && nbeats == 0);
    for (int i = 0; i < nbeats; i++) begin
      d = rnd ? DW'($urandom) : base + DW'(i);
      rec[i*DW +: DW] = d;
      beat_d.push_back(d); beat_l.push_back(last && (i == nbeats - 1));
    end
    if (nbeats < NREG) m_err = 1'b1;
    else begin
      m_regs = rec;
      if (addr < DW'(NB)) begin
        m_blk++; exp_bit.push_back(int'(addr)); exp_regs.push_back(rec);
      end else m_err = 1'b1;
    end
  endtask

  task automatic play(input int gap_pct, input int tog_lo, input int tog_hi);
    int idx, guard;
    idx = 0; guard = 0;
    while (idx < beat_d.size() && guard < 5000) begin
      @(negedge clk); guard++;
      if (idx == tog_lo) start = 1'b0;
      if (idx == tog_hi) start = 1'b1;
      if (int'($urandom_range(99)) < gap_pct) s_axis.tvalid = 1'b0;
      else begin
        s_axis.tvalid = 1'b1; s_axis.tdata = beat_d[idx]; s_axis.tlast = beat_l[idx];
        if (s_axis.tready === 1'b1) idx++;
      end
    end
    chk("beats_accepted", idx, beat_d.size());
    @(negedge clk);
    s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    chk({tag, "_done"}, done, 1);
    @(negedge clk);
    chk({tag, "_npulse"}, got_bit.size(), exp_bit.size());
    for (int i = 0; i < exp_bit.size() && i < got_bit.size(); i++) begin
      chk({tag, "_pbit"}, got_bit[i], exp_bit[i]);
      chk({tag, "_plen"}, got_len[i], WE_LEN);
      chk({tag, "_pregs"}, got_regs[i], exp_regs[i]);
    end
    chk({tag, "_regs"}, regs_out, m_regs);
    chk({tag, "_err"}, err, m_err);
    chk({tag, "_blk"}, blk_cnt, m_blk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_tready"}, s_axis.tready, 0);
  endtask

  initial begin
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tlast = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_we", we, 0); chk("rst_regs", regs_out, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_err", err, 0); chk("rst_blk", blk_cnt, 0);
    chk("rst_tready", s_axis.tready, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single record, exact commit/pulse timing
    start_run();
    add_record(32'd5, NREG, 1'b1, 1'b0, 32'h100);
    play(0, -1, -1);
    chk("t1_we_T1", we, 64'd1 << 5);
    chk("t1_regs_T1", regs_out, m_regs);
    finish_run("t1");

    // 2: three back-to-back records
    start_run();
    add_record(32'd0, NREG, 1'b0, 1'b1, 32'd0);
    add_record(32'd1, NREG, 1'b0, 1'b1, 32'd0);
    add_record(32'd63, NREG, 1'b1, 1'b1, 32'd0);
    play(0, -1, -1);
    finish_run("t2");

    // 3: short frame leaves the bank untouched
    start_run();
    add_record(32'd2, 7, 1'b1, 1'b1, 32'd0);
    play(0, -1, -1);
    finish_run("t3");

    // 4: out-of-range address with upper bits set
    start_run();
    add_record(32'd64, NREG, 1'b1, 1'b1, 32'd0);
    play(0, -1, -1);
    finish_run("t4");

    // 5: stream of test 2 with 50% valid gaps and a mid-frame start glitch
    start_run();
    add_record(32'd0, NREG, 1'b0, 1'b1, 32'd0);
    add_record(32'd1, NREG, 1'b0, 1'b1, 32'd0);
    add_record(32'd63, NREG, 1'b1, 1'b1, 32'd0);
    play(50, 10, 20);
    finish_run("t5");

    // 6: reset while data beat 8 is on the bus
    start_run();
    add_record(32'd9, 8, 1'b0, 1'b1, 32'd0);
    play(0, -1, -1);
    s_axis.tvalid = 1'b1; s_axis.tdata = 32'hDEAD_BEEF; s_axis.tlast = 1'b0;
    rstn = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("t6_we", we, 0); chk("t6_regs", regs_out, 0); chk("t6_busy", busy, 0);
    chk("t6_done", done, 0); chk("t6_err", err, 0); chk("t6_blk", blk_cnt, 0);
    chk("t6_tready", s_axis.tready, 0);
    m_regs = '0;
    @(negedge clk);
    rstn = 1'b1; s_axis.tvalid = 1'b0;
    repeat (2) @(negedge clk);
    start_run();
    add_record(32'd33, NREG, 1'b1, 1'b1, 32'd0);
    play(30, -1, -1);
    finish_run("t6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
